aes_block_sequencer: RTL

- Controller in front of the AES datapath inside the HWPE engine.
- Gathers 32-bit stream words into 128-bit blocks and launches the AES core on each block with a start/done handshake.
- Serialises each 128-bit result back into 32-bit output words.
- Processes a programmed number of blocks per job and reports busy/done to the HWPE controller.

---
 rtl/aes_block_sequencer.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_block_sequencer.sv
// Gathers 32-bit words into 128-bit blocks, runs each through the AES core, and serialises results.
// Define AES_SEQ_PERF_CNT_EN to add the perf_core_cycles_o / perf_stall_cycles_o counters.
module aes_block_sequencer #(
  parameter int unsigned BLK_CNT_W    = 16,
  parameter int unsigned CORE_TIMEOUT = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [BLK_CNT_W-1:0] nb_blocks_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [BLK_CNT_W-1:0] blk_cnt_o,
  input  logic                 in_valid_i,
  input  logic [31:0]          in_data_i,
  output logic                 in_ready_o,
  output logic                 core_start_o,
  output logic [127:0]         core_block_o,
  input  logic                 core_done_i,
  input  logic [127:0]         core_result_i,
  output logic                 out_valid_o,
  output logic [31:0]          out_data_o,
  input  logic                 out_ready_i
`ifdef AES_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]          perf_core_cycles_o,
  output logic [31:0]          perf_stall_cycles_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_LAUNCH,
    S_CORE_WAIT,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_idx;
  logic [127:0]         r_block;
  logic [127:0]         r_result;
  logic [BLK_CNT_W-1:0] r_nb;
  logic [BLK_CNT_W-1:0] r_blk_cnt;
  logic                 r_timeout;
  logic [31:0]          r_wait_cnt;

  logic w_start_acc;
  logic w_in_fire;
  logic w_out_fire;
  logic w_last_word;
  logic w_job_last;
  logic w_core_expired;

  assign w_start_acc    = (r_state == S_IDLE) && start_i && !clear_i;
  assign w_in_fire      = (r_state == S_GATHER) && in_valid_i;
  assign w_out_fire     = (r_state == S_EMIT) && out_ready_i;
  assign w_last_word    = (r_idx == 2'd3);
  assign w_job_last     = ((r_blk_cnt + BLK_CNT_W'(1)) == r_nb);
  // r_wait_cnt holds the number of CORE_WAIT cycles already elapsed.
  assign w_core_expired = (CORE_TIMEOUT != 0) && (r_wait_cnt == 32'(CORE_TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    busy_o       = (r_state != S_IDLE);
    done_o       = 1'b0;
    in_ready_o   = 1'b0;
    core_start_o = 1'b0;
    out_valid_o  = 1'b0;
    if (clear_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            w_state_nxt = (nb_blocks_i == '0) ? S_FINISH : S_GATHER;
          end
        end
        S_GATHER: begin
          if (in_valid_i && w_last_word) begin
            w_state_nxt = S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          w_state_nxt = S_CORE_WAIT;
        end
        S_CORE_WAIT: begin
          if (core_done_i) begin
            w_state_nxt = S_EMIT;
          end else if (w_core_expired) begin
            w_state_nxt = S_FINISH;
          end
        end
        S_EMIT: begin
          if (out_ready_i && w_last_word) begin
            w_state_nxt = w_job_last ? S_FINISH : S_GATHER;
          end
        end
        S_FINISH: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
    unique case (r_state)
      S_GATHER: in_ready_o   = 1'b1;
      S_LAUNCH: core_start_o = 1'b1;
      S_EMIT:   out_valid_o  = 1'b1;
      S_FINISH: done_o       = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx      <= '0;
      r_block    <= '0;
      r_result   <= '0;
      r_nb       <= '0;
      r_blk_cnt  <= '0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else if (clear_i) begin
      r_idx     <= '0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start_acc) begin
            r_nb      <= nb_blocks_i;
            r_blk_cnt <= '0;
            r_timeout <= 1'b0;
            r_idx     <= '0;
          end
        end
        S_GATHER: begin
          if (w_in_fire) begin
            r_block[{r_idx, 5'd0} +: 32] <= in_data_i;
            r_idx                        <= r_idx + 2'd1;
          end
        end
        S_LAUNCH: begin
          r_wait_cnt <= '0;
        end
        S_CORE_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 32'd1;
          if (core_done_i) begin
            r_result <= core_result_i;
          end else if (w_core_expired) begin
            r_timeout <= 1'b1;
          end
        end
        S_EMIT: begin
          if (w_out_fire) begin
            r_idx <= r_idx + 2'd1;
            if (w_last_word) begin
              r_blk_cnt <= r_blk_cnt + BLK_CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign timeout_o    = r_timeout;
  assign blk_cnt_o    = r_blk_cnt;
  assign core_block_o = r_block;
  assign out_data_o   = r_result[{r_idx, 5'd0} +: 32];

`ifdef AES_SEQ_PERF_CNT_EN
  logic [31:0] r_perf_core;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_core  <= '0;
      r_perf_stall <= '0;
    end else if (w_start_acc) begin
      r_perf_core  <= '0;
      r_perf_stall <= '0;
    end else begin
      if ((r_state == S_CORE_WAIT) && (r_perf_core != '1)) begin
        r_perf_core <= r_perf_core + 32'd1;
      end
      if ((r_state == S_EMIT) && !out_ready_i && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_core_cycles_o  = r_perf_core;
  assign perf_stall_cycles_o = r_perf_stall;
`endif

endmodule
